// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: instruction in, datapath controls and debug state out of the control unit
interface multicycle_control_fsm_if #(parameter int IW = 16);
  logic [IW-1:0] instruction;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ALUSrcB, PCSrc, MemToReg;
  logic [2:0] ALUop;
  logic [3:0] state;
  modport master (
    input instruction,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
      ALUSrcB, ALUop, PCSrc, MemToReg, RegWrite, state
  );
  modport slave (
    output instruction,
    input PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
      ALUSrcB, ALUop, PCSrc, MemToReg, RegWrite, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control unit sequencing the 16-bit multi-cycle datapath
// clk, rst (async, active-high); m.instruction in; all datapath enables/selects and m.state out
module multicycle_control_fsm #(
  parameter int IW = 16,
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001
) (
  input logic clk,
  input logic rst,
  multicycle_control_fsm_if.master m
);
  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_LDM = 4'd2, S_LDWB = 4'd3,
    S_STM = 4'd4, S_JMP = 4'd5, S_BRZ = 4'd6, S_REX = 4'd7, S_RWB = 4'd8,
    S_IEX = 4'd9, S_IWB = 4'd10;
  logic [3:0] st, nx, op;
  assign op = m.instruction[IW-1:IW-4];
  assign m.state = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= S_IF;
    else st <= nx;
  always_comb begin
    nx = S_IF;
    case (st)
      S_IF: nx = S_ID;
      S_ID:
        case (op)
          4'b0000: nx = S_LDM;
          4'b0001: nx = S_STM;
          4'b0010: nx = S_JMP;
          4'b0100: nx = S_BRZ;
          4'b1000: nx = S_REX;
          4'b1100, 4'b1101, 4'b1110, 4'b1111: nx = S_IEX;
          default: nx = S_IF;
        endcase
      S_LDM: nx = S_LDWB;
      S_REX: nx = S_RWB;
      S_IEX: nx = S_IWB;
      default: nx = S_IF;
    endcase
  end
  // Outputs are forced low while rst is high even though st already reads S_IF
  always_comb begin
    m.PCWrite = 1'b0;
    m.PCWriteCond = 1'b0;
    m.IorD = 1'b0;
    m.MemRead = 1'b0;
    m.MemWrite = 1'b0;
    m.IRWrite = 1'b0;
    m.ALUSrcA = 1'b0;
    m.ALUSrcB = 2'b00;
    m.ALUop = ALU_ADD;
    m.PCSrc = 2'b00;
    m.MemToReg = 2'b00;
    m.RegWrite = 1'b0;
    if (!rst)
      case (st)
        S_IF: begin
          m.MemRead = 1'b1;
          m.IRWrite = 1'b1;
          m.ALUSrcB = 2'b01;
          m.ALUop = ALU_ADD;
          m.PCWrite = 1'b1;
        end
        S_LDM: begin
          m.MemRead = 1'b1;
          m.IorD = 1'b1;
        end
        S_LDWB: begin
          m.RegWrite = 1'b1;
          m.MemToReg = 2'b01;
        end
        S_STM: begin
          m.MemWrite = 1'b1;
          m.IorD = 1'b1;
        end
        S_JMP: begin
          m.PCWrite = 1'b1;
          m.PCSrc = 2'b10;
        end
        S_BRZ: begin
          m.ALUSrcA = 1'b1;
          m.ALUop = ALU_SUB;
          m.PCWriteCond = 1'b1;
          m.PCSrc = 2'b10;
        end
        S_REX: begin
          m.ALUSrcA = 1'b1;
          m.ALUop = m.instruction[2:0];
        end
        S_RWB: begin
          m.RegWrite = 1'b1;
          m.ALUop = m.instruction[2:0];
        end
        S_IEX: begin
          m.ALUSrcA = 1'b1;
          m.ALUSrcB = 2'b10;
          m.ALUop = {1'b0, op[1:0]};
        end
        S_IWB: begin
          m.RegWrite = 1'b1;
          m.ALUop = {1'b0, op[1:0]};
        end
        default: ;
      endcase
  end
  always_comb begin
    assert (!(m.PCWrite && m.PCWriteCond));
    assert (!(m.MemRead && m.MemWrite));
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed self-checking bench for the multi-cycle control unit
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  multicycle_control_fsm_if #(.IW(16)) bus ();
  multicycle_control_fsm #(.IW(16)) dut (.clk(clk), .rst(rst), .m(bus));
  always #5 clk = ~clk;
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,ALUSrcA,ALUSrcB,ALUop,PCSrc,MemToReg,RegWrite}
  logic [16:0] ctl;
  assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
    bus.ALUSrcA, bus.ALUSrcB, bus.ALUop, bus.PCSrc, bus.MemToReg, bus.RegWrite};
  localparam logic [16:0] C_NONE = 17'b0;
  localparam logic [16:0] C_IF   = 17'b1_0_0_1_0_1_0_01_000_00_00_0;
  localparam logic [16:0] C_LDM  = 17'b0_0_1_1_0_0_0_00_000_00_00_0;
  localparam logic [16:0] C_LDWB = 17'b0_0_0_0_0_0_0_00_000_00_01_1;
  localparam logic [16:0] C_STM  = 17'b0_0_1_0_1_0_0_00_000_00_00_0;
  localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_00_000_10_00_0;
  localparam logic [16:0] C_BRZ  = 17'b0_1_0_0_0_0_1_00_001_10_00_0;
  localparam logic [16:0] C_REX  = 17'b0_0_0_0_0_0_1_00_011_00_00_0;
  localparam logic [16:0] C_RWB  = 17'b0_0_0_0_0_0_0_00_011_00_00_1;
  localparam logic [16:0] C_IEX  = 17'b0_0_0_0_0_0_1_10_001_00_00_0;
  localparam logic [16:0] C_IWB  = 17'b0_0_0_0_0_0_0_00_001_00_00_1;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (bus.state !== 4'd0 || ctl !== C_NONE) begin
        mismatched++;
        $display("FAIL reset_hold[%0d]: state %0d ctl %b, expected state 0 ctl %b", i, bus.state, ctl, C_NONE);
      end
    end
    rst = 1'b0;
    #1;
    compared++;
    if (bus.state !== 4'd0 || ctl !== C_IF) begin
      mismatched++;
      $display("FAIL reset_release: state %0d ctl %b, expected state 0 ctl %b", bus.state, ctl, C_IF);
    end
    bus.instruction = 16'h0123;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (bus.state !== 4'd2) begin
      mismatched++;
      $display("FAIL reset_reach_ldm: state %0d, expected 2", bus.state);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (bus.state !== 4'd0 || ctl !== C_NONE) begin
        mismatched++;
        $display("FAIL reset_mid_ldm[%0d]: state %0d ctl %b, expected state 0 ctl %b", i, bus.state, ctl, C_NONE);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (bus.state !== 4'd0 || ctl !== C_IF) begin
      mismatched++;
      $display("FAIL reset_rerelease: state %0d ctl %b, expected state 0 ctl %b", bus.state, ctl, C_IF);
    end
  endtask

  task automatic test_load();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [16:0] ec [5] = '{C_IF, C_NONE, C_LDM, C_LDWB, C_IF};
    bus.instruction = 16'h0123;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (bus.state !== es[i] || ctl !== ec[i]) begin
        mismatched++;
        $display("FAIL load[%0d]: state %0d ctl %b, expected state %0d ctl %b", i, bus.state, ctl, es[i], ec[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] es [7] = '{4'd0, 4'd1, 4'd4, 4'd0, 4'd1, 4'd5, 4'd0};
    logic [16:0] ec [7] = '{C_IF, C_NONE, C_STM, C_IF, C_NONE, C_JMP, C_IF};
    bus.instruction = 16'h1050;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) bus.instruction = 16'h2ABC;
      compared++;
      if (bus.state !== es[i] || ctl !== ec[i]) begin
        mismatched++;
        $display("FAIL store_jump[%0d]: state %0d ctl %b, expected state %0d ctl %b", i, bus.state, ctl, es[i], ec[i]);
      end
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic test_brz();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd6, 4'd0};
    logic [16:0] ec [4] = '{C_IF, C_NONE, C_BRZ, C_IF};
    bus.instruction = 16'h4010;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (bus.state !== es[i] || ctl !== ec[i]) begin
        mismatched++;
        $display("FAIL brz[%0d]: state %0d ctl %b, expected state %0d ctl %b", i, bus.state, ctl, es[i], ec[i]);
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic test_alu();
    logic [3:0] es [9] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    logic [16:0] ec [9] = '{C_IF, C_NONE, C_REX, C_RWB, C_IF, C_NONE, C_IEX, C_IWB, C_IF};
    bus.instruction = 16'h8203;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) bus.instruction = 16'hDFFF;
      compared++;
      if (bus.state !== es[i] || ctl !== ec[i]) begin
        mismatched++;
        $display("FAIL rtype_subi[%0d]: state %0d ctl %b, expected state %0d ctl %b", i, bus.state, ctl, es[i], ec[i]);
      end
      if (i < 8) @(negedge clk);
    end
  endtask

  task automatic test_nop_illegal();
    logic [3:0] es [3] = '{4'd0, 4'd1, 4'd0};
    logic [16:0] ec [3] = '{C_IF, C_NONE, C_IF};
    bus.instruction = 16'h3000;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (bus.state !== es[i] || ctl !== ec[i]) begin
        mismatched++;
        $display("FAIL nop[%0d]: state %0d ctl %b, expected state %0d ctl %b", i, bus.state, ctl, es[i], ec[i]);
      end
      if (i < 2) @(negedge clk);
    end
    force dut.st = 4'd13;
    #1;
    release dut.st;
    #1;
    compared++;
    if (bus.state !== 4'd13 || ctl !== C_NONE) begin
      mismatched++;
      $display("FAIL illegal_hold: state %0d ctl %b, expected state 13 ctl %b", bus.state, ctl, C_NONE);
    end
    @(negedge clk);
    compared++;
    if (bus.state !== 4'd0 || ctl !== C_IF) begin
      mismatched++;
      $display("FAIL illegal_recover: state %0d ctl %b, expected state 0 ctl %b", bus.state, ctl, C_IF);
    end
  endtask

  initial begin
    bus.instruction = 16'h0000;
    test_reset();
    test_load();
    test_back_to_back();
    test_brz();
    test_alu();
    test_nop_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
